// File: rtl/grid_mem_arbiter.sv
// Arbitrates one single-port grid RAM between VGA pixel fetch (priority) and the game engine.
// Optional whole-grid clear sweep is built when GRID_CLEAR_EN is defined.
module grid_mem_arbiter #(
  parameter int GRID_W_LOG = 4,
  parameter int GRID_H_LOG = 4,
  parameter int DATA_W     = 2,
  parameter int STARVE_MAX = 8,
  localparam int ADDR_W    = GRID_W_LOG + GRID_H_LOG
) (
  input  logic              board_clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  output logic              vga_drop,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_ack,
  output logic [DATA_W-1:0] game_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

`ifdef GRID_CLEAR_EN
  typedef enum logic [1:0] {IDLE, GAME_PEND, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, GAME_PEND} state_t;
`endif

  typedef enum logic [1:0] {TAG_VGA, TAG_GRD, TAG_GWR, TAG_CLR} tag_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     starve_cnt, starve_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic              game_grant, clr_slot, drop_nxt;
  logic              slot_en, slot_we;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;
  tag_t              slot_tag;
  logic              vld_p1, vld_p2;
  tag_t              tag_p1, tag_p2;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_MAX)) ? v : v + 1'b1;
  endfunction

`ifndef GRID_CLEAR_EN
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
`endif

  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    clr_ptr_nxt = clr_ptr;
    game_grant  = 1'b0;
    clr_slot    = 1'b0;
    case (state)
      IDLE: begin
        // Starved game request wins the slot even against a pending VGA fetch.
        if (game_req && (!vga_req || starve_cnt == SW'(STARVE_MAX))) begin
          game_grant = 1'b1;
          state_nxt  = GAME_PEND;
          starve_nxt = '0;
        end else begin
          if (game_req) starve_nxt = sat_inc(starve_cnt);
`ifdef GRID_CLEAR_EN
          if (clr_start) state_nxt = CLEAR;
`endif
        end
      end
      GAME_PEND: begin
        if (game_ack) state_nxt = IDLE;
      end
`ifdef GRID_CLEAR_EN
      CLEAR: begin
        if (!vga_req) begin
          clr_slot    = 1'b1;
          clr_ptr_nxt = clr_ptr + 1'b1;
          if (clr_ptr == '1) state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    slot_en    = 1'b0;
    slot_we    = 1'b0;
    slot_addr  = '0;
    slot_wdata = '0;
    slot_tag   = TAG_VGA;
    drop_nxt   = game_grant && vga_req;
    if (game_grant) begin
      slot_en    = 1'b1;
      slot_we    = game_we;
      slot_addr  = game_addr;
      slot_wdata = game_wdata;
      slot_tag   = game_we ? TAG_GWR : TAG_GRD;
    end else if (vga_req) begin
      slot_en   = 1'b1;
      slot_addr = vga_addr;
    end else if (clr_slot) begin
      slot_en   = 1'b1;
      slot_we   = 1'b1;
      slot_addr = clr_ptr;
      slot_tag  = TAG_CLR;
    end
  end

`ifdef GRID_CLEAR_EN
  assign clr_busy = (state == CLEAR);
`else
  assign clr_busy = 1'b0;
`endif

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      clr_ptr    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      tag_p1     <= TAG_VGA;
      tag_p2     <= TAG_VGA;
      vga_drop   <= 1'b0;
      vga_rvalid <= 1'b0;
      vga_rdata  <= '0;
      game_ack   <= 1'b0;
      game_rdata <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      clr_ptr    <= clr_ptr_nxt;
      // p1: slot issued on the RAM port
      mem_en     <= slot_en;
      mem_we     <= slot_we;
      mem_addr   <= slot_addr;
      mem_wdata  <= slot_wdata;
      vld_p1     <= slot_en;
      tag_p1     <= slot_tag;
      vga_drop   <= drop_nxt;
      // p2: RAM returns read data; writes complete here
      vld_p2     <= vld_p1;
      tag_p2     <= tag_p1;
      game_ack   <= (vld_p1 && tag_p1 == TAG_GWR) || (vld_p2 && tag_p2 == TAG_GRD);
      // p3: read data routed to its owner
      vga_rvalid <= vld_p2 && tag_p2 == TAG_VGA;
      if (vld_p2 && tag_p2 == TAG_VGA) vga_rdata  <= mem_rdata;
      if (vld_p2 && tag_p2 == TAG_GRD) game_rdata <= mem_rdata;
    end
  end

endmodule
